vga_draw_arbiter: RTL and testbench

- Sits directly downstream of the paddle, ball and score drawing blocks and upstream of the VGA adapter.
- Grants the single VGA write port to one drawing client at a time, round-robin.
- Issues each granted client its one-cycle go pulse, forwards that client's pixel stream (x, y, colour, write strobe) to the adapter, and releases the port on the client's done rising edge.

---
 rtl/vga_draw_pkg.sv | 17 +
 rtl/rr_picker.sv | 30 +++
 rtl/vga_draw_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_vga_draw_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_draw_pkg.sv
// Widths and arbiter state encoding shared by the VGA drawing blocks
// (paddle, ball, score) and the draw-port arbiter.
package vga_draw_pkg;

  localparam int X_W             = 8;
  localparam int Y_W             = 7;
  localparam int C_W             = 3;
  localparam int DEFAULT_TIMEOUT = 20000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set req bit at or after ptr,
// wrapping modulo N_CLIENTS.
module rr_picker #(
  parameter int N_CLIENTS = 4
) (
  input  logic [N_CLIENTS-1:0] req,
  input  logic [2:0]           ptr,
  output logic                 valid,
  output logic [2:0]           index
);

  localparam logic [3:0] N_L = 4'(N_CLIENTS);

  logic [N_CLIENTS-1:0] rot_s;
  logic [2:0]           off_s;
  logic [3:0]           sum_s;

  // Rotate so that ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot_s = N_CLIENTS'({req, req} >> ptr);
    off_s = 3'd0;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? 3'(k) : off_s;
    end
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    index = (sum_s >= N_L) ? 3'(sum_s - N_L) : sum_s[2:0];
    valid = |req;
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the single VGA write port among the drawing clients.
// Optional stalled-turn watchdog and timeout port: define DRAW_ARB_TIMEOUT_EN.
module vga_draw_arbiter #(
`ifdef DRAW_ARB_TIMEOUT_EN
  parameter int TIMEOUT   = vga_draw_pkg::DEFAULT_TIMEOUT,
`endif
  parameter int N_CLIENTS = 4,
  parameter int X_W       = vga_draw_pkg::X_W,
  parameter int Y_W       = vga_draw_pkg::Y_W,
  parameter int C_W       = vga_draw_pkg::C_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_CLIENTS-1:0]     req,
  input  logic [N_CLIENTS-1:0]     done,
  input  logic [N_CLIENTS-1:0]     we_in,
  input  logic [N_CLIENTS*X_W-1:0] x_in,
  input  logic [N_CLIENTS*Y_W-1:0] y_in,
  input  logic [N_CLIENTS*C_W-1:0] colour_in,
  output logic [N_CLIENTS-1:0]     go,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [C_W-1:0]           colour,
  output logic                     plot,
  output logic [2:0]               owner,
`ifdef DRAW_ARB_TIMEOUT_EN
  output logic                     timeout,
`endif
  output logic                     busy
);

  import vga_draw_pkg::*;

  localparam logic [2:0] LAST = 3'(N_CLIENTS - 1);

  arb_state_e           state_q, state_d;
  logic [2:0]           ptr_q, ptr_d, owner_q, owner_d;
  logic [N_CLIENTS-1:0] go_q, go_d, done_q, done_d;
  logic                 plot_q, plot_d, busy_q, busy_d;
  logic [X_W-1:0]       x_q, x_d, own_x_s;
  logic [Y_W-1:0]       y_q, y_d, own_y_s;
  logic [C_W-1:0]       colour_q, colour_d, own_c_s;
  logic                 own_we_s, own_done_s, own_done_prev_s, done_edge_s, finish_s;
  logic                 pick_valid_s;
  logic [2:0]           pick_idx_s;
`ifdef DRAW_ARB_TIMEOUT_EN
  logic [14:0]          wd_q, wd_d;
  logic                 timeout_q, timeout_d, wd_hit_s;
`endif

  rr_picker #(.N_CLIENTS(N_CLIENTS)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid_s),
    .index (pick_idx_s)
  );

  // Owner's lane of the pixel buses and its done level plus last-cycle done.
  always_comb begin
    own_we_s        = 1'b0;
    own_done_s      = 1'b0;
    own_done_prev_s = 1'b0;
    own_x_s         = {X_W{1'b0}};
    own_y_s         = {Y_W{1'b0}};
    own_c_s         = {C_W{1'b0}};
    for (int i = 0; i < N_CLIENTS; i++) begin
      own_we_s        = (owner_q == 3'(i)) ? we_in[i]              : own_we_s;
      own_done_s      = (owner_q == 3'(i)) ? done[i]               : own_done_s;
      own_done_prev_s = (owner_q == 3'(i)) ? done_q[i]             : own_done_prev_s;
      own_x_s         = (owner_q == 3'(i)) ? x_in[i*X_W +: X_W]      : own_x_s;
      own_y_s         = (owner_q == 3'(i)) ? y_in[i*Y_W +: Y_W]      : own_y_s;
      own_c_s         = (owner_q == 3'(i)) ? colour_in[i*C_W +: C_W] : own_c_s;
    end
    done_edge_s = own_done_s & ~own_done_prev_s;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    go_d     = {N_CLIENTS{1'b0}};
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    done_d   = done;
    finish_s = done_edge_s;
`ifdef DRAW_ARB_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = 1'b0;
    wd_hit_s  = (wd_q == 15'(TIMEOUT - 1));
    finish_s  = done_edge_s | wd_hit_s;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d = GRANT;
          owner_d = pick_idx_s;
          busy_d  = 1'b1;
          for (int i = 0; i < N_CLIENTS; i++) begin
            go_d[i] = (pick_idx_s == 3'(i));
          end
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        state_d = BUSY;
        busy_d  = 1'b1;
`ifdef DRAW_ARB_TIMEOUT_EN
        wd_d    = 15'd0;
`endif
      end
      BUSY: begin
        // The pixel on the cycle the turn ends is still forwarded.
        plot_d   = own_we_s;
        x_d      = own_x_s;
        y_d      = own_y_s;
        colour_d = own_c_s;
        if (finish_s) begin
          state_d = GAP;
          ptr_d   = (owner_q == LAST) ? 3'd0 : owner_q + 3'd1;
          busy_d  = 1'b0;
`ifdef DRAW_ARB_TIMEOUT_EN
          timeout_d = ~done_edge_s;
`endif
        end else begin
          busy_d = 1'b1;
`ifdef DRAW_ARB_TIMEOUT_EN
          wd_d   = wd_q + 15'd1;
`endif
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, done history and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      owner_q   <= 3'd0;
      go_q      <= {N_CLIENTS{1'b0}};
      done_q    <= {N_CLIENTS{1'b0}};
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      x_q       <= {X_W{1'b0}};
      y_q       <= {Y_W{1'b0}};
      colour_q  <= {C_W{1'b0}};
`ifdef DRAW_ARB_TIMEOUT_EN
      wd_q      <= 15'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      go_q      <= go_d;
      done_q    <= done_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
`ifdef DRAW_ARB_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign go     = go_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign owner  = owner_q;
  assign busy   = busy_q;
`ifdef DRAW_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Randomized scoreboard bench for vga_draw_arbiter: the driver pushes the
// expected grants and pixels, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_vga_draw_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   req, done, we_in;
  logic [N*8-1:0] x_in;
  logic [N*7-1:0] y_in;
  logic [N*3-1:0] colour_in;
  logic [N-1:0]   go;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic           plot;
  logic [2:0]     owner;
  logic           busy;
`ifdef DRAW_ARB_TIMEOUT_EN
  logic           timeout;
`endif

  int tests = 0;
  int fails = 0;
  int plot_seen = 0;
  int ptr_m = 0;
  int go_exp_q[$];
  logic [17:0] pix_exp_q[$];
  int mon_e;
  logic [17:0] mon_pv;

  always #5 clk = ~clk;

  vga_draw_arbiter #(
    .N_CLIENTS(N), .X_W(8), .Y_W(7), .C_W(3)
`ifdef DRAW_ARB_TIMEOUT_EN
    , .TIMEOUT(100)
`endif
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .done(done), .we_in(we_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .go(go), .x(x), .y(y),
    .colour(colour), .plot(plot), .owner(owner),
`ifdef DRAW_ARB_TIMEOUT_EN
    .timeout(timeout),
`endif
    .busy(busy)
  );

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference pick: first requester at or after p, wrapping.
  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic put_pix(input int c, input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    we_in[c] = 1'b1;
    x_in[c*8 +: 8] = px;
    y_in[c*7 +: 7] = py;
    colour_in[c*3 +: 3] = pc;
    pix_exp_q.push_back({px, py, pc});
  endtask

  task automatic noise(input int own);
    for (int i = 0; i < N; i++) begin
      if (i != own) begin
        we_in[i] = 1'($urandom);
        done[i] = 1'($urandom);
        x_in[i*8 +: 8] = 8'($urandom);
        y_in[i*7 +: 7] = 7'($urandom);
        colour_in[i*3 +: 3] = 3'($urandom);
      end
    end
  endtask

  task automatic wait_go(output int n);
    n = 0;
    @(negedge clk);
    while (go == 4'b0 && n < 8) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Called at posedge+1 of an IDLE cycle with req already holding this turn's mask.
  task automatic turn(input logic [N-1:0] mask_next, input int ncyc, input bit fixed,
                      input bit stale, input bit edge_pix);
    int exp, n, pushed, seen0;
    bit busy_ok;
    exp = rr_pick(req, ptr_m);
    go_exp_q.push_back(exp);
    done[exp] = stale;
    @(negedge clk);
    check("idle_quiet", go == 4'b0 && busy == 1'b0, {go, busy}, 0);
    wait_go(n);
    check("go_latency", n == 0, n, 0);
    seen0 = plot_seen;
    pushed = 0;
    busy_ok = 1'b1;
    for (int p = 0; p < ncyc; p++) begin
      @(posedge clk); #1;
      if (fixed) begin
        put_pix(exp, 8'(75 + p), 7'd12, 3'b010);
        pushed++;
      end else begin
        noise(exp);
        if ($urandom_range(3, 0) != 0) begin
          put_pix(exp, 8'($urandom), 7'($urandom), 3'($urandom));
          pushed++;
        end else begin
          we_in[exp] = 1'b0;
        end
      end
      if (stale && p == ncyc / 2) done[exp] = 1'b0;
      @(negedge clk);
      if (p == 0) check("go_single", go == 4'b0, go, 0);
      busy_ok &= (busy == 1'b1);
    end
    @(posedge clk); #1;
    if (!fixed) noise(exp);
    done[exp] = 1'b1;
    if (edge_pix) begin
      put_pix(exp, 8'($urandom), 7'($urandom), 3'($urandom));
      pushed++;
    end else begin
      we_in[exp] = 1'b0;
    end
    @(negedge clk);
    check("busy_hold", busy_ok && busy == 1'b1, busy, 1);
    @(posedge clk); #1;
    req = mask_next;
    we_in = 4'b0;
    @(negedge clk);
    check("gap_busy_low", busy == 1'b0, busy, 0);
    @(posedge clk); #1;
    check("plot_count", plot_seen - seen0 == pushed, plot_seen - seen0, pushed);
    ptr_m = (exp + 1) % N;
  endtask

  // Monitor: every grant and every plotted pixel is matched against the queues.
  always @(negedge clk) begin
    if (resetn) begin
      if (go != 4'b0) begin
        if (go_exp_q.size() == 0) begin
          check("go_unexpected", 1'b0, go, 0);
        end else begin
          mon_e = go_exp_q.pop_front();
          check("go_onehot", go == N'(1 << mon_e), go, 1 << mon_e);
          check("owner", owner == 3'(mon_e), owner, mon_e);
          check("busy_grant", busy == 1'b1, busy, 1);
        end
      end
      if (plot) begin
        plot_seen++;
        if (pix_exp_q.size() == 0) begin
          check("plot_unexpected", 1'b0, {x, y, colour}, 0);
        end else begin
          mon_pv = pix_exp_q.pop_front();
          check("pixel", {x, y, colour} == mon_pv, {x, y, colour}, mon_pv);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d, expected %0d", tests, 0);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int nc;
    logic [N-1:0] m;
    resetn = 1'b0;
    req = 4'b0; done = 4'b0; we_in = 4'b0;
    x_in = '0; y_in = '0; colour_in = '0;
    repeat (3) @(negedge clk);
    check("rst_go", go == 4'b0, go, 0);
    check("rst_busy_plot", busy == 1'b0 && plot == 1'b0, {busy, plot}, 0);
    check("rst_owner", owner == 3'd0, owner, 0);
    check("rst_pixel", {x, y, colour} == 18'd0, {x, y, colour}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    req = 4'b1111;

    // Round robin with every client requesting: 0,1,2,3,0.
    for (int t = 0; t < 4; t++) turn(4'b1111, 4, 1'b0, 1'b0, 1'b0);
    turn(4'b0010, 4, 1'b0, 1'b0, 1'b0);

    // Single client 1 streaming x = 75..90.
    turn(4'b1000, 16, 1'b1, 1'b0, 1'b0);

    // Client 3 already holds done high when granted.
    turn(4'(($urandom_range(14, 0)) + 1), 6, 1'b0, 1'b1, 1'b1);

    // Random masks, lengths, noisy non-owner lanes.
    for (int t = 0; t < 20; t++) begin
      m = (t == 19) ? 4'b0100 : 4'($urandom_range(15, 1));
      nc = $urandom_range(8, 1);
      turn(m, nc, 1'b0, (nc >= 2) && ($urandom_range(1, 0) == 1), $urandom_range(1, 0) == 1);
    end

    // Reset in the middle of client 2's turn.
    go_exp_q.push_back(2);
    done[2] = 1'b0;
    wait_go(n);
    check("rst_test_grant", n < 8, n, 1);
    for (int p = 0; p < 3; p++) begin
      @(posedge clk); #1;
      put_pix(2, 8'($urandom), 7'($urandom), 3'($urandom));
      @(negedge clk);
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check("async_rst_go", go == 4'b0, go, 0);
    check("async_rst_plot", plot == 1'b0, plot, 0);
    check("async_rst_busy", busy == 1'b0, busy, 0);
    pix_exp_q.delete();
    go_exp_q.delete();
    ptr_m = 0;
    we_in = 4'b0;
    done = 4'b0;
    @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    req = 4'b1111;
`ifdef DRAW_ARB_TIMEOUT_EN
    turn(4'b0011, 3, 1'b0, 1'b0, 1'b0);
    // Owner never finishes: watchdog ends the turn after 100 BUSY cycles.
    n = rr_pick(req, ptr_m);
    go_exp_q.push_back(n);
    done[n] = 1'b0;
    ptr_m = (n + 1) % N;
    wait_go(nc);
    nc = 0;
    while (timeout !== 1'b1 && nc < 200) begin
      @(negedge clk);
      nc++;
    end
    check("timeout_cycle", nc == 101, nc, 101);
    check("timeout_busy_low", busy == 1'b0, busy, 0);
    @(posedge clk); #1;
    turn(4'b0000, 3, 1'b0, 1'b0, 1'b0);
`else
    turn(4'b0000, 3, 1'b0, 1'b0, 1'b0);
`endif
    repeat (2) @(negedge clk);
    check("queues_drained", go_exp_q.size() == 0 && pix_exp_q.size() == 0,
          go_exp_q.size() + pix_exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
